// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetches and data accesses onto one memory port
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_ren,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_stall,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_stall,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, INST, DATA} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, inst_data_q, inst_data_d, mem_din_q, mem_din_d;
  logic              we_q, we_d, inst_done_q, inst_done_d, data_done_q, data_done_d;
  logic [3:0]        burst_q, burst_d;
  logic              data_req, inst_win, can_grant;
  assign data_req   = mem_ren | mem_wen;
  assign inst_win   = inst_ren & (~data_req | (burst_q == 4'(MAX_DATA_BURST)));
  // a done pulse blocks granting so the requester can drop or replace its request
  assign can_grant  = (state_q == IDLE) & ~inst_done_q & ~data_done_q;
  assign ram_cs     = state_q != IDLE;
  assign busy       = state_q != IDLE;
  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign inst_data  = inst_data_q;
  assign mem_din    = mem_din_q;
  assign inst_stall = inst_ren & ~inst_done_q;
  assign mem_stall  = data_req & ~data_done_q;
  // next-state: grant in IDLE, hold the access until ack, latch read data on ack
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    burst_d     = burst_q;
    inst_data_d = inst_data_q;
    mem_din_d   = mem_din_q;
    inst_done_d = (state_q == INST) & ram_ack;
    data_done_d = (state_q == DATA) & ram_ack;
    if (state_q == IDLE) begin
      if (!inst_ren) burst_d = '0;
      if (can_grant && inst_win) begin
        state_d = INST;
        addr_d  = inst_addr;
        we_d    = 1'b0;
        burst_d = '0;
      end else if (can_grant && data_req) begin
        state_d = DATA;
        addr_d  = mem_addr;
        wdata_d = mem_dout;
        we_d    = mem_wen;
        if (inst_ren && burst_q != 4'(MAX_DATA_BURST)) burst_d = burst_q + 4'd1;
      end
    end else if (ram_ack) begin
      state_d = IDLE;
      if (state_q == INST) inst_data_d = ram_rdata;
      if (state_q == DATA && !we_q) mem_din_d = ram_rdata;
    end
  end
  // state and datapath registers, cleared asynchronously so a reset abandons any access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      burst_q     <= '0;
      inst_data_q <= '0;
      mem_din_q   <= '0;
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      burst_q     <= burst_d;
      inst_data_q <= inst_data_d;
      mem_din_q   <= mem_din_d;
      inst_done_q <= inst_done_d;
      data_done_q <= data_done_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        inst_ren = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0, ram_ack = 1'b0;
  logic [31:0] inst_addr = '0, mem_addr = '0, mem_dout = '0, ram_rdata = '0;
  logic [31:0] inst_data, mem_din, ram_addr, ram_wdata;
  logic        inst_stall, mem_stall, ram_cs, ram_we, busy;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] exp_addr [6] = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h30, 32'h200};

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_stall(inst_stall),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_stall(mem_stall),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_cs", 64'(ram_cs), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(ram_addr), 64'd0);
    chk("rst_inst_data", 64'(inst_data), 64'd0);
    chk("rst_mem_din", 64'(mem_din), 64'd0);
    rst_n = 1'b1;
    tick();
    // single fetch, ack in the first cs cycle
    inst_ren = 1'b1; inst_addr = 32'h10;
    #1;
    chk("f_stall_req", 64'(inst_stall), 64'd1);
    chk("f_busy_req", 64'(busy), 64'd0);
    tick();
    chk("f_cs", 64'(ram_cs), 64'd1);
    chk("f_addr", 64'(ram_addr), 64'h10);
    chk("f_we", 64'(ram_we), 64'd0);
    chk("f_stall_cs", 64'(inst_stall), 64'd1);
    ram_ack = 1'b1; ram_rdata = 32'h2402_0005;
    tick();
    chk("f_cs_off", 64'(ram_cs), 64'd0);
    chk("f_data", 64'(inst_data), 64'h2402_0005);
    chk("f_stall_done", 64'(inst_stall), 64'd0);
    ram_ack = 1'b0; inst_ren = 1'b0;
    tick();
    chk("f_idle", 64'(busy), 64'd0);
    // simultaneous fetch and data read: data first, fetch after data_done
    inst_ren = 1'b1; inst_addr = 32'h20; mem_ren = 1'b1; mem_addr = 32'h100;
    tick();
    chk("c_addr_data", 64'(ram_addr), 64'h100);
    chk("c_cs", 64'(ram_cs), 64'd1);
    chk("c_istall", 64'(inst_stall), 64'd1);
    chk("c_mstall", 64'(mem_stall), 64'd1);
    ram_ack = 1'b1; ram_rdata = 32'hAAAA_5555;
    tick();
    chk("c_mem_din", 64'(mem_din), 64'hAAAA_5555);
    chk("c_mstall_done", 64'(mem_stall), 64'd0);
    chk("c_istall_hold", 64'(inst_stall), 64'd1);
    chk("c_no_grant_done", 64'(ram_cs), 64'd0);
    ram_ack = 1'b0; mem_ren = 1'b0;
    tick();
    chk("c_idle_gap", 64'(ram_cs), 64'd0);
    chk("c_istall_gap", 64'(inst_stall), 64'd1);
    tick();
    chk("c_inst_cs", 64'(ram_cs), 64'd1);
    chk("c_inst_addr", 64'(ram_addr), 64'h20);
    ram_ack = 1'b1; ram_rdata = 32'h0000_1111;
    tick();
    chk("c_inst_data", 64'(inst_data), 64'h1111);
    chk("c_istall_done", 64'(inst_stall), 64'd0);
    chk("c_mem_din_kept", 64'(mem_din), 64'hAAAA_5555);
    ram_ack = 1'b0; inst_ren = 1'b0;
    tick();
    // write with ack in the fourth cs cycle
    mem_wen = 1'b1; mem_addr = 32'h40; mem_dout = 32'hDEAD_BEEF; ram_rdata = 32'h9999_9999;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w_hold%0d", i), {29'd0, ram_cs, ram_we, mem_stall, ram_addr}, {29'd0, 3'b111, 32'h40});
      chk($sformatf("w_wdata%0d", i), 64'(ram_wdata), 64'hDEAD_BEEF);
      if (i == 3) ram_ack = 1'b1;
      tick();
    end
    chk("w_cs_off", 64'(ram_cs), 64'd0);
    chk("w_mstall", 64'(mem_stall), 64'd0);
    chk("w_mem_din_kept", 64'(mem_din), 64'hAAAA_5555);
    ram_ack = 1'b0; mem_wen = 1'b0;
    #1;
    chk("w_mstall_drop", 64'(mem_stall), 64'd0);
    tick();
    // data burst with fetch held: four data grants then one fetch
    inst_ren = 1'b1; inst_addr = 32'h30; mem_ren = 1'b1; mem_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("b_cs%0d", k), 64'(ram_cs), 64'd1);
      chk($sformatf("b_addr%0d", k), 64'(ram_addr), 64'(exp_addr[k]));
      ram_ack = 1'b1;
      tick();
      ram_ack = 1'b0;
      tick();
    end
    inst_ren = 1'b0; mem_ren = 1'b0;
    tick();
    chk("b_idle", 64'(busy), 64'd0);
    // reset during a data access, late ack ignored
    mem_ren = 1'b1; mem_addr = 32'h300; ram_rdata = 32'h1234_5678;
    tick();
    chk("r_cs", 64'(ram_cs), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("r_cs0", 64'(ram_cs), 64'd0);
    chk("r_busy0", 64'(busy), 64'd0);
    chk("r_regs0", {ram_addr, ram_wdata}, 64'd0);
    chk("r_outs0", {inst_data, mem_din}, 64'd0);
    chk("r_we0", 64'(ram_we), 64'd0);
    chk("r_mstall", 64'(mem_stall), 64'd1);
    mem_ren = 1'b0;
    tick();
    rst_n = 1'b1; ram_ack = 1'b1;
    tick();
    chk("r_late_busy", 64'(busy), 64'd0);
    chk("r_late_din", 64'(mem_din), 64'd0);
    ram_ack = 1'b0;
    inst_ren = 1'b1; inst_addr = 32'h44;
    tick();
    chk("r_next_addr", 64'(ram_addr), 64'h44);
    ram_ack = 1'b1; ram_rdata = 32'h5;
    tick();
    chk("r_next_data", 64'(inst_data), 64'h5);
    chk("r_next_stall", 64'(inst_stall), 64'd0);
    ram_ack = 1'b0; inst_ren = 1'b0;
    tick();
    // read withdrawn after grant still completes
    mem_ren = 1'b1; mem_addr = 32'h500;
    tick();
    chk("x_cs", 64'(ram_cs), 64'd1);
    mem_ren = 1'b0;
    #1;
    chk("x_mstall", 64'(mem_stall), 64'd0);
    chk("x_busy", 64'(busy), 64'd1);
    ram_ack = 1'b1; ram_rdata = 32'h77;
    tick();
    chk("x_din", 64'(mem_din), 64'h77);
    chk("x_cs_off", 64'(ram_cs), 64'd0);
    ram_ack = 1'b0;
    tick();
    chk("x_idle", 64'(busy), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, sets the address width of all ports.
REQ-002 Parameter DATA_W, default 32, sets the data width of all ports.
REQ-003 Parameter MAX_DATA_BURST, default 4, sets the maximum consecutive data grants while a fetch is pending; legal range 1..15.
REQ-004 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-005 Ports SHALL be as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- inst_ren  in  1  fetch request, held until inst_stall=0.
- inst_addr  in  ADDR_W  fetch address.
- inst_data  out  DATA_W  fetched word, valid while inst_stall=0 after a grant.
- inst_stall  out  1  fetch not complete.
- mem_ren  in  1  data read request.
- mem_wen  in  1  data write request.
- mem_addr  in  ADDR_W  data address.
- mem_dout  in  DATA_W  write data.
- mem_din  out  DATA_W  read data.
- mem_stall  out  1  data access not complete.
- ram_cs  out  1  unified memory select.
- ram_we  out  1  write strobe.
- ram_addr  out  ADDR_W  memory address.
- ram_wdata  out  DATA_W  memory write data.
- ram_rdata  in  DATA_W  memory read data.
- ram_ack  in  1  access complete; sampled only while ram_cs=1.
- busy  out  1  state is not IDLE.

Function
REQ-006 The FSM SHALL have three states: IDLE, INST and DATA.
REQ-007 In IDLE, a data request (mem_ren|mem_wen) SHALL win over inst_ren, except when burst_cnt==MAX_DATA_BURST and inst_ren=1; in that case INST wins.
REQ-008 The grant SHALL register the address, write data and we into ram_addr/ram_wdata/ram_we and move to INST or DATA; ram_cs=1 from the next cycle.
REQ-009 In INST/DATA, ram_cs, ram_addr, ram_we and ram_wdata SHALL hold constant until a cycle with ram_ack=1; on that edge the state returns to IDLE and ram_cs deasserts.
REQ-010 On ack in INST, ram_rdata SHALL be latched into inst_data and inst_done pulses for exactly one cycle.
REQ-011 On ack in DATA, ram_rdata SHALL be latched into mem_din only if ram_we=0, and data_done pulses for one cycle.
REQ-012 inst_stall SHALL equal inst_ren & ~inst_done, and mem_stall SHALL equal (mem_ren|mem_wen) & ~data_done; both are combinational.
REQ-013 Minimum latency SHALL be: request in IDLE at cycle N, ram_cs=1 at N+1, ack at N+1, stall low at N+2.
REQ-014 No new grant SHALL occur in a cycle where a done pulse is high, so the requester can drop or replace its request.
REQ-015 burst_cnt (4 bits) SHALL increment on each DATA grant while inst_ren=1, saturating at MAX_DATA_BURST.
REQ-016 burst_cnt SHALL clear on an INST grant or when inst_ren=0 in IDLE.
REQ-017 A started transaction SHALL always complete even if its request is withdrawn (pipeline flush); its done pulse still occurs, and the latched data is overwritten by a later access.
REQ-018 mem_ren and mem_wen both high SHALL be treated as a write.
REQ-019 No ram_ack SHALL leave the FSM waiting indefinitely; no timeout is provided.

Reset
REQ-020 rst_n=0 SHALL immediately force: state IDLE, ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0, inst_data=0, mem_din=0, burst_cnt=0, done flags=0, busy=0.
REQ-021 Reset mid-transaction SHALL abandon the access, and a late ram_ack after reset SHALL be ignored.

Verification
REQ-022 inst_ren=1, inst_addr=0x10, ram_ack returned one cycle after ram_cs with ram_rdata=0x2402_0005 -> ram_addr=0x10, ram_we=0; inst_data=0x2402_0005 and inst_stall=0 exactly 2 cycles after the request.
REQ-023 inst_ren=1 (0x20) and mem_ren=1 (0x100) in the same cycle, ack latency 1 -> DATA is served first with mem_din latched; INST is granted in the cycle after data_done; inst_stall stays high throughout the data access.
REQ-024 mem_wen=1, mem_addr=0x40, mem_dout=0xDEAD_BEEF, ack delayed 3 cycles -> ram_we=1 and address/data stable for all 4 cs cycles; mem_din unchanged; mem_stall low for one cycle.
REQ-025 MAX_DATA_BURST=4, continuous data requests with inst_ren held -> exactly 4 DATA grants, then 1 INST grant, then the burst count restarts.
REQ-026 rst_n pulsed low during DATA with cs=1, then ram_ack=1 after release -> all outputs are at reset values immediately, the late ack causes no done pulse, and the next request is served normally.
REQ-027 mem_ren withdrawn in the cycle after grant -> the access completes, one data_done cycle occurs, mem_stall stays 0, and the FSM returns to IDLE.
